// File: rtl/burst_mem_responder_pkg.sv
// ============================================================
// Package : burst_mem_responder_pkg
// Shared defaults and FSM state encoding. Rev 1.0
// ============================================================
`default_nettype none

package burst_mem_responder_pkg;

    localparam int C_DATA_WIDTH = 32;
    localparam int C_MEM_AW     = 10;

    localparam logic [1:0] C_ST_IDLE    = 2'd0;
    localparam logic [1:0] C_ST_RD_WAIT = 2'd1;
    localparam logic [1:0] C_ST_RD_DATA = 2'd2;
    localparam logic [1:0] C_ST_WR_DATA = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = C_ST_IDLE,
        ST_RD_WAIT = C_ST_RD_WAIT,
        ST_RD_DATA = C_ST_RD_DATA,
        ST_WR_DATA = C_ST_WR_DATA
    } state_e;

endpackage

`default_nettype wire

// File: rtl/burst_mem_responder_array.sv
// ============================================================
// Module : burst_mem_array
// Single-port synchronous RAM, registered read, no reset. Rev 1.0
// ============================================================
`default_nettype none

module burst_mem_array
    import burst_mem_responder_pkg::*;
#(
    parameter int DATA_WIDTH = C_DATA_WIDTH,
    parameter int ADDR_WIDTH = C_MEM_AW
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata_q <= mem[addr];
    end

    assign rdata = rdata_q;

endmodule

`default_nettype wire

// File: rtl/burst_mem_responder.sv
// ============================================================
// Module : burst_mem_responder
// One-burst-at-a-time memory responder with read/write channels. Rev 1.0
// ============================================================
`default_nettype none

module burst_mem_responder
    import burst_mem_responder_pkg::*;
#(
    parameter int DATA_WIDTH = C_DATA_WIDTH,
    parameter int MEM_AW     = C_MEM_AW,
    parameter int RESP_DELAY = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           rd_req_addr,
    input  logic [4:0]            rd_req_len,
    input  logic                  rd_req_valid,
    output logic                  rd_req_ready,
    output logic [DATA_WIDTH-1:0] rd_rdata,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic                  rd_last,
    input  logic [31:0]           wr_req_addr,
    input  logic [4:0]            wr_req_len,
    input  logic                  wr_req_valid,
    output logic                  wr_req_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic                  wr_last,
    output logic                  err
);

    localparam logic [3:0]        C_DLY     = 4'(RESP_DELAY);
    localparam logic [MEM_AW-1:0] C_IDX_ONE = MEM_AW'(1);

    state_e                state_q, state_d;
    logic [MEM_AW-1:0]     idx_q, idx_d;
    logic [4:0]            len_q, len_d;
    logic [4:0]            beat_q, beat_d;
    logic [3:0]            dly_q, dly_d;
    logic [DATA_WIDTH-1:0] rd_rdata_q, rd_rdata_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  rd_last_q, rd_last_d;
    logic                  req_ready_q, req_ready_d;
    logic                  wr_ready_q, wr_ready_d;
    logic                  err_q, err_d;

    logic [MEM_AW-1:0]     w_ram_addr;
    logic [DATA_WIDTH-1:0] w_ram_rdata;
    logic                  w_ram_we;
    logic                  w_rd_hs;
    logic                  w_wr_hs;
    logic                  w_wr_final;
    logic                  w_unused;

    assign w_rd_hs    = rd_valid_q && rd_ready;
    assign w_wr_hs    = wr_ready_q && wr_valid;
    assign w_wr_final = (beat_q == len_q);
    assign w_ram_we   = (state_q == ST_WR_DATA) && w_wr_hs;
    // Reads address the RAM with the next index so the word to present next
    // is already on the RAM output when a beat is loaded (back-to-back beats).
    assign w_ram_addr = (state_q == ST_WR_DATA) ? idx_q : idx_d;
    assign w_unused   = ^{rd_req_addr[31:MEM_AW+2], rd_req_addr[1:0],
                          wr_req_addr[31:MEM_AW+2], wr_req_addr[1:0]};

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        len_d      = len_q;
        beat_d     = beat_q;
        dly_d      = dly_q;
        rd_rdata_d = rd_rdata_q;
        rd_valid_d = rd_valid_q;
        rd_last_d  = rd_last_q;
        err_d      = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_ready_q && rd_req_valid) begin
                    state_d = ST_RD_WAIT;
                    idx_d   = rd_req_addr[MEM_AW+1:2];
                    len_d   = rd_req_len;
                    beat_d  = 5'd0;
                    dly_d   = 4'd0;
                end else if (req_ready_q && wr_req_valid) begin
                    state_d = ST_WR_DATA;
                    idx_d   = wr_req_addr[MEM_AW+1:2];
                    len_d   = wr_req_len;
                    beat_d  = 5'd0;
                end
            end
            ST_RD_WAIT: begin
                if (dly_q == C_DLY) begin
                    state_d    = ST_RD_DATA;
                    rd_valid_d = 1'b1;
                    rd_rdata_d = w_ram_rdata;
                    rd_last_d  = (len_q == 5'd0);
                    idx_d      = idx_q + C_IDX_ONE;
                end else begin
                    dly_d = dly_q + 4'd1;
                end
            end
            ST_RD_DATA: begin
                if (w_rd_hs) begin
                    if (rd_last_q) begin
                        state_d    = ST_IDLE;
                        rd_valid_d = 1'b0;
                        rd_last_d  = 1'b0;
                        beat_d     = 5'd0;
                        dly_d      = 4'd0;
                    end else begin
                        beat_d     = beat_q + 5'd1;
                        rd_rdata_d = w_ram_rdata;
                        rd_last_d  = ((beat_q + 5'd1) == len_q);
                        idx_d      = idx_q + C_IDX_ONE;
                    end
                end
            end
            ST_WR_DATA: begin
                if (w_wr_hs) begin
                    idx_d  = idx_q + C_IDX_ONE;
                    beat_d = beat_q + 5'd1;
                    // wr_last must mark exactly the final counted beat
                    if (wr_last != w_wr_final) begin
                        err_d = 1'b1;
                    end
                    if (w_wr_final) begin
                        state_d = ST_IDLE;
                        beat_d  = 5'd0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        req_ready_d = (state_d == ST_IDLE);
        wr_ready_d  = (state_d == ST_WR_DATA);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            len_q       <= 5'd0;
            beat_q      <= 5'd0;
            dly_q       <= 4'd0;
            rd_rdata_q  <= '0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
            req_ready_q <= 1'b0;
            wr_ready_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            len_q       <= len_d;
            beat_q      <= beat_d;
            dly_q       <= dly_d;
            rd_rdata_q  <= rd_rdata_d;
            rd_valid_q  <= rd_valid_d;
            rd_last_q   <= rd_last_d;
            req_ready_q <= req_ready_d;
            wr_ready_q  <= wr_ready_d;
            err_q       <= err_d;
        end
    end

    burst_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (MEM_AW)
    ) u_mem (
        .clk   (clk),
        .we    (w_ram_we),
        .addr  (w_ram_addr),
        .wdata (wr_data),
        .rdata (w_ram_rdata)
    );

    assign rd_req_ready = req_ready_q;
    assign wr_req_ready = req_ready_q;
    assign rd_rdata     = rd_rdata_q;
    assign rd_valid     = rd_valid_q;
    assign rd_last      = rd_last_q;
    assign wr_ready     = wr_ready_q;
    assign err          = err_q;

endmodule

`default_nettype wire

// File: tb/tb_burst_mem_responder.sv
// ============================================================
// Module : tb_burst_mem_responder
// Directed scoreboard bench for burst_mem_responder. Rev 1.0
// ============================================================
`default_nettype none

module tb_burst_mem_responder;

    localparam int RESP_DELAY = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] rd_req_addr, wr_req_addr;
    logic [4:0]  rd_req_len, wr_req_len;
    logic        rd_req_valid, rd_req_ready, wr_req_valid, wr_req_ready;
    logic [31:0] rd_rdata, wr_data;
    logic        rd_valid, rd_ready, rd_last;
    logic        wr_valid, wr_ready, wr_last, err;

    typedef struct packed {
        logic [31:0] d;
        logic        l;
    } beat_t;

    beat_t       exp_q[$];
    logic [31:0] mem_model [1024];
    int          total = 0;
    int          bad = 0;
    logic        bp_stall = 1'b0;
    logic [31:0] hold_d;
    logic        hold_l;

    always #5 clk = ~clk;

    burst_mem_responder #(
        .DATA_WIDTH (32),
        .MEM_AW     (10),
        .RESP_DELAY (RESP_DELAY)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rd_req_addr  (rd_req_addr),
        .rd_req_len   (rd_req_len),
        .rd_req_valid (rd_req_valid),
        .rd_req_ready (rd_req_ready),
        .rd_rdata     (rd_rdata),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_last      (rd_last),
        .wr_req_addr  (wr_req_addr),
        .wr_req_len   (wr_req_len),
        .wr_req_valid (wr_req_valid),
        .wr_req_ready (wr_req_ready),
        .wr_data      (wr_data),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_last      (wr_last),
        .err          (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] widx(input logic [31:0] a, input int i);
        logic [9:0] b;
        b = a[11:2];
        return b + 10'(i);
    endfunction

    // Read-data monitor: pops the scoreboard on each handshake and checks
    // that a stalled beat stays put until it is taken.
    always @(negedge clk) begin
        if (!rst_n) begin
            bp_stall = 1'b0;
        end else begin
            if (bp_stall) begin
                check("hold_valid", {31'd0, rd_valid}, 32'd1);
                check("hold_data", rd_rdata, hold_d);
                check("hold_last", {31'd0, rd_last}, {31'd0, hold_l});
            end
            if (rd_valid && rd_ready) begin
                total++;
                assert (exp_q.size() > 0) else begin
                    bad++;
                    $error("FAIL unexpected_beat observed=0x%0h expected=none", rd_rdata);
                end
                if (exp_q.size() > 0) begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check("rd_data", rd_rdata, e.d);
                    check("rd_last", {31'd0, rd_last}, {31'd0, e.l});
                end
            end
            bp_stall = rd_valid && !rd_ready;
            hold_d   = rd_rdata;
            hold_l   = rd_last;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req_write(input logic [31:0] a, input logic [4:0] l);
        int n;
        wr_req_addr  = a;
        wr_req_len   = l;
        wr_req_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!wr_req_ready && n < 60);
        check("wr_req_accept", {31'd0, wr_req_ready}, 32'd1);
        tick();
        wr_req_valid = 1'b0;
    endtask

    task automatic wr_beats(input logic [31:0] a, input int l, input int last_idx, input logic [31:0] base);
        int n;
        for (int i = 0; i <= l; i++) begin
            wr_valid = 1'b1;
            wr_data  = base + 32'(i);
            wr_last  = (i == last_idx);
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!wr_ready && n < 20);
            check("wr_ready_beat", {31'd0, wr_ready}, 32'd1);
            tick();
            mem_model[widx(a, i)] = base + 32'(i);
        end
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        check("wr_ready_after_burst", {31'd0, wr_ready}, 32'd0);
    endtask

    task automatic req_read(input logic [31:0] a, input logic [4:0] l);
        int n;
        for (int i = 0; i <= int'(l); i++) begin
            exp_q.push_back('{d: mem_model[widx(a, i)], l: (i == int'(l))});
        end
        rd_req_addr  = a;
        rd_req_len   = l;
        rd_req_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rd_req_ready && n < 60);
        check("rd_req_accept", {31'd0, rd_req_ready}, 32'd1);
        tick();
        rd_req_valid = 1'b0;
    endtask

    task automatic rd_run(input logic toggle);
        int cyc;
        int lat;
        cyc = 0;
        lat = -1;
        rd_ready = !toggle;
        while (exp_q.size() > 0 && cyc < 200) begin
            @(posedge clk);
            cyc++;
            #1;
            if (lat < 0 && rd_valid) lat = cyc;
            if (toggle) rd_ready = ~rd_ready;
        end
        check("rd_drain", 32'(exp_q.size()), 32'd0);
        if (!toggle) check("rd_first_latency", 32'(lat), 32'(RESP_DELAY + 1));
        check("rd_valid_after_burst", {31'd0, rd_valid}, 32'd0);
        check("rd_last_after_burst", {31'd0, rd_last}, 32'd0);
        check("idle_after_read", {31'd0, rd_req_ready}, 32'd1);
        rd_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0;
        rd_req_addr = '0; rd_req_len = '0; rd_req_valid = 1'b0; rd_ready = 1'b0;
        wr_req_addr = '0; wr_req_len = '0; wr_req_valid = 1'b0;
        wr_data = '0; wr_valid = 1'b0; wr_last = 1'b0;
        repeat (3) tick();
        check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        check("rst_rd_last", {31'd0, rd_last}, 32'd0);
        check("rst_rd_rdata", rd_rdata, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_rd_req_ready", {31'd0, rd_req_ready}, 32'd0);
        check("rst_wr_req_ready", {31'd0, wr_req_ready}, 32'd0);
        rst_n = 1'b1;
        tick();
        check("post_rst_rd_req_ready", {31'd0, rd_req_ready}, 32'd1);
        check("post_rst_wr_req_ready", {31'd0, wr_req_ready}, 32'd1);

        // Basic write then streaming read-back
        req_write(32'h100, 5'd7);
        wr_beats(32'h100, 7, 7, 32'hA0);
        check("write_err", {31'd0, err}, 32'd0);
        req_read(32'h100, 5'd7);
        rd_run(1'b0);

        // Backpressure
        req_read(32'h100, 5'd3);
        rd_run(1'b1);

        // Wrap around the top of the word space
        req_write(32'hFF8, 5'd3);
        wr_beats(32'hFF8, 3, 3, 32'hC0);
        req_read(32'hFF8, 5'd3);
        rd_run(1'b0);
        req_read(32'h0, 5'd1);
        rd_run(1'b0);

        // Simultaneous requests: read first, write waits
        wr_req_addr  = 32'h200;
        wr_req_len   = 5'd2;
        wr_req_valid = 1'b1;
        req_read(32'h104, 5'd1);
        check("collision_wr_req_held", {31'd0, wr_req_ready}, 32'd0);
        check("collision_no_wr_ready", {31'd0, wr_ready}, 32'd0);
        rd_run(1'b0);
        req_write(32'h200, 5'd2);
        wr_beats(32'h200, 2, 2, 32'hD0);
        check("collision_err", {31'd0, err}, 32'd0);
        req_read(32'h200, 5'd2);
        rd_run(1'b0);

        // Misplaced wr_last
        req_write(32'h300, 5'd1);
        wr_beats(32'h300, 1, 0, 32'hE0);
        check("err_set", {31'd0, err}, 32'd1);
        req_read(32'h300, 5'd1);
        rd_run(1'b0);
        check("err_sticky", {31'd0, err}, 32'd1);

        // Reset in the middle of a read burst
        req_read(32'h100, 5'd7);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rd_valid && n < 20);
        check("midrd_valid_seen", {31'd0, rd_valid}, 32'd1);
        rd_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("midrd_rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        check("midrd_rst_rd_rdata", rd_rdata, 32'd0);
        check("midrd_rst_err", {31'd0, err}, 32'd0);
        check("midrd_rst_rd_req_ready", {31'd0, rd_req_ready}, 32'd0);
        exp_q.delete();
        rd_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("midrd_post_rd_req_ready", {31'd0, rd_req_ready}, 32'd1);
        check("midrd_post_rd_valid", {31'd0, rd_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
